// File: rtl/sfr_apb_bridge_if.sv
// APB3 slave and SFR-bank master signals handled by sfr_apb_bridge.
// The slave modport is the bridge's view; master is the upstream/bank environment.
interface sfr_apb_bridge_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;
   logic [ADDR_WIDTH-1:0] sfr_address;
   logic [DATA_WIDTH-1:0] sfr_write_data;
   logic                  sfr_we;
   logic                  sfr_re;
   logic [DATA_WIDTH-1:0] sfr_read_data;

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, sfr_read_data,
      output prdata, pready, pslverr, sfr_address, sfr_write_data, sfr_we, sfr_re
   );

   modport master (
      output psel, penable, pwrite, paddr, pwdata, sfr_read_data,
      input  prdata, pready, pslverr, sfr_address, sfr_write_data, sfr_we, sfr_re
   );
endinterface

// File: rtl/sfr_apb_bridge.sv
// APB3 slave to SFR-bank bridge: one SFR strobe per APB transfer, fixed read
// latency, PSLVERR on out-of-range addresses, saturating error counter.
module sfr_apb_bridge #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          DATA_WIDTH = 8,
   parameter int unsigned NUM_REGS   = 256,
   parameter int          RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   sfr_apb_bridge_if.slave         bus,
   output logic [7:0]              err_count
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [3:0] RD_CNT  = 4'(RD_LATENCY - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       setup;
   logic       addr_err;
   logic       start_err;

   assign setup     = bus.psel && !bus.penable;
   assign addr_err  = 32'(bus.paddr) >= NUM_REGS;
   // An access phase seen while idle has no setup behind it: answer with an error.
   assign start_err = bus.psel && (bus.penable || addr_err);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= S_IDLE;
         cnt                <= '0;
         err_count          <= '0;
         bus.prdata         <= '0;
         bus.pready         <= 1'b0;
         bus.pslverr        <= 1'b0;
         bus.sfr_address    <= '0;
         bus.sfr_write_data <= '0;
         bus.sfr_we         <= 1'b0;
         bus.sfr_re         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_err) begin
                  state       <= S_DONE;
                  bus.pready  <= 1'b1;
                  bus.pslverr <= 1'b1;
                  bus.prdata  <= '0;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               end else if (setup && bus.pwrite) begin
                  state              <= S_WRITE;
                  bus.sfr_we         <= 1'b1;
                  bus.sfr_address    <= bus.paddr;
                  bus.sfr_write_data <= bus.pwdata;
               end else if (setup) begin
                  state           <= S_READ;
                  bus.sfr_re      <= 1'b1;
                  bus.sfr_address <= bus.paddr;
                  cnt             <= RD_CNT;
               end
            end
            S_WRITE: begin
               bus.sfr_we <= 1'b0;
               if (!bus.psel) begin
                  state <= S_IDLE;
               end else begin
                  state      <= S_DONE;
                  bus.pready <= 1'b1;
               end
            end
            S_READ: begin
               if (!bus.psel) begin
                  state      <= S_IDLE;
                  bus.sfr_re <= 1'b0;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state      <= S_DONE;
                  bus.sfr_re <= 1'b0;
                  bus.pready <= 1'b1;
                  bus.prdata <= bus.sfr_read_data;
               end
            end
            default: begin
               state       <= S_IDLE;
               bus.pready  <= 1'b0;
               bus.pslverr <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sfr_apb_bridge.sv
// Directed bench: u0 (256 regs, read latency 3) and u1 (16 regs, read latency 1)
// share APB stimulus; psel is steered to one instance at a time.
module tb_sfr_apb_bridge;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sel = 1'b0;
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] paddr = '0, pwdata = '0;
   logic       ovr_en = 1'b0;
   logic [7:0] ovr_data = '0;
   logic [7:0] rd1 = 8'h5A;
   logic [7:0] mem0 [256];
   logic [7:0] err0, err1;

   int n_chk = 0, n_fail = 0;
   int acc, we_cnt, re_cnt;
   logic [7:0] we_a, we_d, r_data;
   logic r_err, got_rdy, seen;

   always #5 clk = ~clk;

   sfr_apb_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b0 ();
   sfr_apb_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();

   assign b0.psel = psel && !sel;
   assign b1.psel = psel && sel;
   assign b0.penable = penable;  assign b1.penable = penable;
   assign b0.pwrite  = pwrite;   assign b1.pwrite  = pwrite;
   assign b0.paddr   = paddr;    assign b1.paddr   = paddr;
   assign b0.pwdata  = pwdata;   assign b1.pwdata  = pwdata;
   assign b0.sfr_read_data = ovr_en ? ovr_data : mem0[b0.sfr_address];
   assign b1.sfr_read_data = rd1;

   always @(posedge clk) if (b0.sfr_we) mem0[b0.sfr_address] <= b0.sfr_write_data;

   sfr_apb_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(256), .RD_LATENCY(3))
      u0 (.clk(clk), .reset(reset), .bus(b0), .err_count(err0));
   sfr_apb_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(16), .RD_LATENCY(1))
      u1 (.clk(clk), .reset(reset), .bus(b1), .err_count(err1));

   logic       m_we, m_re, m_pready, m_pslverr;
   logic [7:0] m_addr, m_wdata, m_prdata;
   assign m_we      = sel ? b1.sfr_we : b0.sfr_we;
   assign m_re      = sel ? b1.sfr_re : b0.sfr_re;
   assign m_pready  = sel ? b1.pready : b0.pready;
   assign m_pslverr = sel ? b1.pslverr : b0.pslverr;
   assign m_addr    = sel ? b1.sfr_address : b0.sfr_address;
   assign m_wdata   = sel ? b1.sfr_write_data : b0.sfr_write_data;
   assign m_prdata  = sel ? b1.prdata : b0.prdata;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Setup then access until pready (bounded); leaves psel high for back-to-back.
   task automatic xfer(input logic s, input logic proto, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
      acc = 0; we_cnt = 0; re_cnt = 0; got_rdy = 1'b0;
      r_data = '0; r_err = 1'b0; we_a = '0; we_d = '0;
      @(posedge clk); #1;
      sel = s; psel = 1'b1; penable = proto; pwrite = wr; paddr = a; pwdata = d;
      for (int i = 0; i < 40 && !got_rdy; i++) begin
         @(posedge clk); #1;
         penable = 1'b1; acc++;
         @(negedge clk);
         if (m_we) begin we_cnt++; we_a = m_addr; we_d = m_wdata; end
         if (m_re) re_cnt++;
         chk("we_re_exclusive", {31'd0, m_we & m_re}, 0);
         if (m_pready) begin got_rdy = 1'b1; r_data = m_prdata; r_err = m_pslverr; end
      end
      chk("pready_timeout", {31'd0, got_rdy}, 1);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (n - 1) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
      #12;
      chk("rst_pready", {31'd0, b0.pready}, 0);
      chk("rst_sfr_addr", {24'd0, b0.sfr_address}, 0);
      chk("rst_err_count", {24'd0, err0}, 0);
      reset = 1'b1;
      idle(2);

      // write 0x55 -> 0x10
      xfer(0, 0, 1, 8'h10, 8'h55);
      chk("wr_access_cycles", acc, 2);
      chk("wr_we_cycles", we_cnt, 1);
      chk("wr_sfr_addr", {24'd0, we_a}, 32'h10);
      chk("wr_sfr_data", {24'd0, we_d}, 32'h55);
      chk("wr_re_cycles", re_cnt, 0);
      chk("wr_pslverr", {31'd0, r_err}, 0);
      idle(2);

      // read 0x10 with bank forcing 0xA3, latency 3
      ovr_en = 1'b1; ovr_data = 8'hA3;
      xfer(0, 0, 0, 8'h10, 8'h00);
      chk("rd_access_cycles", acc, 4);
      chk("rd_re_cycles", re_cnt, 3);
      chk("rd_prdata", {24'd0, r_data}, 32'hA3);
      chk("rd_pslverr", {31'd0, r_err}, 0);
      idle(2);
      ovr_en = 1'b0;
      chk("rd_prdata_hold", {24'd0, b0.prdata}, 32'hA3);

      // access phase with no setup
      xfer(0, 1, 0, 8'h10, 8'h00);
      chk("proto_access_cycles", acc, 1);
      chk("proto_pslverr", {31'd0, r_err}, 1);
      chk("proto_prdata", {24'd0, r_data}, 0);
      chk("proto_no_strobe", we_cnt + re_cnt, 0);
      chk("proto_err_count", {24'd0, err0}, 1);
      idle(1);
      @(negedge clk);
      chk("proto_pslverr_clear", {31'd0, b0.pslverr}, 0);

      // back-to-back write 0x01 -> 0x00, then read 0x00
      xfer(0, 0, 1, 8'h00, 8'h01);
      chk("b2b_wr_cycles", acc, 2);
      xfer(0, 0, 0, 8'h00, 8'h00);
      chk("b2b_rd_cycles", acc, 4);
      chk("b2b_rd_data", {24'd0, r_data}, 32'h01);
      idle(2);

      // async reset in READ
      @(posedge clk); #1;
      sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("rst_pre_re", {31'd0, b0.sfr_re}, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_re", {31'd0, b0.sfr_re}, 0);
      chk("rst_async_addr", {24'd0, b0.sfr_address}, 0);
      chk("rst_async_prdata", {24'd0, b0.prdata}, 0);
      chk("rst_async_err", {24'd0, err0}, 0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("rst_held_re", {31'd0, b0.sfr_re}, 0);
      #2 reset = 1'b1;
      xfer(0, 0, 1, 8'h05, 8'h77);
      chk("post_rst_wr_cycles", acc, 2);
      xfer(0, 0, 0, 8'h05, 8'h00);
      chk("post_rst_rd_data", {24'd0, r_data}, 32'h77);
      chk("post_rst_rd_cycles", acc, 4);
      idle(2);

      // psel dropped mid-read
      @(posedge clk); #1;
      sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort_re_on", {31'd0, b0.sfr_re}, 1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_re_off", {31'd0, b0.sfr_re}, 0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (b0.pready) seen = 1'b1;
      end
      chk("abort_no_pready", {31'd0, seen}, 0);
      chk("abort_err_count", {24'd0, err0}, 0);
      xfer(0, 0, 0, 8'h05, 8'h00);
      chk("abort_next_rd", {24'd0, r_data}, 32'h77);
      idle(2);

      // 16-register instance: good read, then out-of-range errors
      xfer(1, 0, 0, 8'h03, 8'h00);
      chk("u1_rd_cycles", acc, 2);
      chk("u1_rd_data", {24'd0, r_data}, 32'h5A);
      chk("u1_err_before", {24'd0, err1}, 0);
      xfer(1, 0, 0, 8'h20, 8'h00);
      chk("oor_rd_cycles", acc, 1);
      chk("oor_rd_no_re", re_cnt, 0);
      chk("oor_rd_pslverr", {31'd0, r_err}, 1);
      chk("oor_rd_prdata", {24'd0, r_data}, 0);
      chk("oor_err_count", {24'd0, err1}, 1);
      xfer(1, 0, 1, 8'h10, 8'hEE);
      chk("oor_wr_no_we", we_cnt, 0);
      chk("oor_wr_pslverr", {31'd0, r_err}, 1);
      for (int i = 0; i < 298; i++) xfer(1, 0, 0, 8'hF0, 8'h00);
      chk("err_count_300", {24'd0, err1}, 255);
      xfer(1, 0, 0, 8'h40, 8'h00);
      chk("err_count_sat", {24'd0, err1}, 255);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
